// File: rtl/rmii_recv_word.sv
// RMII receive front end: samples 2-bit RMII at 100/10 Mbit/s, finds preamble/SFD, packs payload into
// BYTES-wide words with sof/eof/keep and reports FCS, length and alignment status on the eof word.
module rmii_recv_word #(
  parameter int BYTES    = 4,
  parameter int GAP_10M  = 18,
  parameter int TAIL_10M = 1,
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 1522
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rmii_clk,
  input  logic               fast_eth,
  input  logic [1:0]         rm_rx_data,
  input  logic               rm_crs_dv,
  output logic [8*BYTES-1:0] data,
  output logic [BYTES-1:0]   keep,
  output logic               valid,
  output logic               sof,
  output logic               eof,
  output logic               crc_ok,
  output logic               err_len,
  output logic               err_align,
  output logic               busy
);

  localparam int LW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int GW = $clog2(GAP_10M + 2);
  localparam int TW = $clog2(TAIL_10M + 2);
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {IDLE, HUNT, DATA, TAIL, FIN, DROP} state_t;
  state_t r_state, w_next;

  logic                    s_rmii_clk, s_crs_dv;
  logic [1:0]              s_rxd;
  logic                    r_rst_q, r_fast, r_hold_vld, r_sof_pend;
  logic [GW-1:0]           r_gap;
  logic [7:0]              r_sr, r_byte;
  logic [1:0]              r_dib;
  logic [15:0]             r_cnt;
  logic [LW-1:0]           r_lane;
  logic [TW-1:0]           r_tail;
  logic [31:0]             r_crc;
  logic [BYTES-1:0][7:0]   r_word, r_hold, w_word;
  logic [BYTES-1:0]        w_pkeep;
  logic [7:0]              w_dbyte;
  logic w_fast, w_samp, w_bdone, w_ovf, w_cut, w_align, w_end, w_eof, w_full, w_shift, w_sfd, w_tail_last;

  // Ethernet CRC in non-reflected register form, data fed LSB first.
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++)
      x = {x[30:0], 1'b0} ^ ((x[31] ^ b[i]) ? 32'h04C11DB7 : 32'h0);
    return x;
  endfunction

  always_ff @(posedge clk) begin
    s_rmii_clk <= rmii_clk;
    s_crs_dv   <= rm_crs_dv;
    s_rxd      <= rm_rx_data;
  end

  always_comb begin
    w_fast      = (r_state == IDLE) ? fast_eth : r_fast;
    w_samp      = s_rmii_clk && (r_gap == '0);
    w_dbyte     = {s_rxd, r_byte[7:2]};
    w_sfd       = (r_state == HUNT) && w_samp && s_crs_dv && (r_sr == 8'hD5);
    w_bdone     = w_samp && (r_dib == 2'd3) &&
                  (((r_state == DATA) && s_crs_dv) || (r_state == TAIL));
    w_ovf       = w_bdone && (r_cnt == 16'(MAX_LEN));
    w_cut       = w_samp && (r_state == DATA) && !s_crs_dv;
    w_align     = w_cut && (r_dib != 2'd0);
    w_end       = (w_cut && ((r_dib != 2'd0) || r_fast || (TAIL_10M == 0))) || (r_state == FIN);
    w_eof       = (w_end && (r_cnt != 16'd0)) || w_ovf;
    // On a 10M boundary cut the dibit under the falling crs_dv is the first of the tail byte.
    w_shift     = w_samp && (((r_state == DATA) && (s_crs_dv || (w_cut && !w_end))) ||
                             (r_state == TAIL));
    w_tail_last = w_bdone && (r_state == TAIL) && (r_tail == TW'(TAIL_10M - 1));
    w_full      = (r_lane == LW'(BYTES - 1));
    w_word      = r_word;
    w_word[r_lane] = w_dbyte;
    for (int i = 0; i < BYTES; i++)
      w_pkeep[i] = (32'(i) < 32'(r_lane));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (r_rst_q && s_crs_dv) w_next = DROP;
            else if (w_samp && s_crs_dv) w_next = HUNT;
      HUNT: if (w_samp) begin
              if (!s_crs_dv)           w_next = IDLE;
              else if (r_sr == 8'hD5)  w_next = DATA;
            end
      DATA: if (w_ovf)       w_next = DROP;
            else if (w_end)  w_next = IDLE;
            else if (w_cut)  w_next = TAIL;
      TAIL: if (w_ovf)            w_next = DROP;
            else if (w_tail_last) w_next = FIN;
      FIN:  w_next = IDLE;
      DROP: if (w_samp && !s_crs_dv) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;      r_rst_q <= 1'b1;     r_fast <= fast_eth;
      r_gap <= '0;          r_sr <= '0;          r_byte <= '0;
      r_dib <= '0;          r_cnt <= '0;         r_lane <= '0;
      r_tail <= '0;         r_crc <= '1;         r_word <= '0;
      r_hold <= '0;         r_hold_vld <= 1'b0;  r_sof_pend <= 1'b0;
      data <= '0;           keep <= '0;          valid <= 1'b0;
      sof <= 1'b0;          eof <= 1'b0;         crc_ok <= 1'b0;
      err_len <= 1'b0;      err_align <= 1'b0;   busy <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rst_q <= 1'b0;
      if (r_state == IDLE) r_fast <= fast_eth;
      if (w_samp && !w_fast)  r_gap <= GW'(GAP_10M);
      else if (r_gap != '0)   r_gap <= r_gap - 1'b1;

      valid <= 1'b0; sof <= 1'b0; eof <= 1'b0;
      crc_ok <= 1'b0; err_len <= 1'b0; err_align <= 1'b0;

      if ((r_state == IDLE || r_state == HUNT) && w_samp)
        r_sr <= (s_crs_dv && !w_sfd) ? {s_rxd, r_sr[7:2]} : 8'h00;
      else if (r_state != IDLE && r_state != HUNT)
        r_sr <= 8'h00;

      if (w_sfd) begin
        busy <= 1'b1;     r_byte <= w_dbyte;   r_dib <= 2'd1;
        r_cnt <= '0;      r_lane <= '0;        r_tail <= '0;
        r_crc <= '1;      r_word <= '0;        r_hold_vld <= 1'b0;
        r_sof_pend <= 1'b1;
      end

      if (w_shift) begin
        r_byte <= w_dbyte;
        r_dib  <= r_dib + 1'b1;
      end

      // The overflow byte is discarded; eof rides on the bytes already collected.
      if (w_bdone && !w_ovf) begin
        r_crc <= crc8(r_crc, w_dbyte);
        r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        if (r_state == TAIL) r_tail <= r_tail + 1'b1;
        if (r_hold_vld) begin
          valid <= 1'b1; data <= r_hold; keep <= '1;
          sof <= r_sof_pend; r_sof_pend <= 1'b0; r_hold_vld <= 1'b0;
        end
        if (w_full) begin
          r_hold <= w_word; r_hold_vld <= 1'b1; r_word <= '0; r_lane <= '0;
        end else begin
          r_word <= w_word; r_lane <= r_lane + 1'b1;
        end
      end

      if (w_eof) begin
        valid     <= 1'b1;
        eof       <= 1'b1;
        sof       <= r_sof_pend;
        data      <= r_hold_vld ? r_hold : r_word;
        keep      <= r_hold_vld ? {BYTES{1'b1}} : w_pkeep;
        crc_ok    <= !w_ovf && (r_crc == RESIDUE);
        err_len   <= w_ovf || (r_cnt < 16'(MIN_LEN)) || (r_cnt > 16'(MAX_LEN));
        err_align <= w_align;
      end
      if (w_eof || w_end) begin
        busy <= 1'b0; r_sof_pend <= 1'b0; r_hold_vld <= 1'b0;
        r_word <= '0; r_lane <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rmii_recv_word.sv
// Directed bench for rmii_recv_word: builds Ethernet frames with software FCS and checks the word stream.
module tb_rmii_recv_word;
  localparam int BYTES = 4;

  logic clk = 1'b0, rst = 1'b1, rmii_clk = 1'b0, fast_eth = 1'b1;
  logic [1:0] rxd = 2'b00;
  logic crs = 1'b0;
  logic [8*BYTES-1:0] data;
  logic [BYTES-1:0] keep;
  logic valid, sof, eof, crc_ok, err_len, err_align, busy;

  rmii_recv_word #(.BYTES(BYTES), .GAP_10M(18), .TAIL_10M(1), .MIN_LEN(64), .MAX_LEN(1522)) dut (
    .clk(clk), .rst(rst), .rmii_clk(rmii_clk), .fast_eth(fast_eth),
    .rm_rx_data(rxd), .rm_crs_dv(crs),
    .data(data), .keep(keep), .valid(valid), .sof(sof), .eof(eof),
    .crc_ok(crc_ok), .err_len(err_len), .err_align(err_align), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial begin #2; forever #10 rmii_clk = ~rmii_clk; end

  int n_err = 0, n_chk = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: cumulative counters, sampled away from the active edge.
  int cyc = 0, nw = 0, neof = 0, nsof = 0, eof_nw = 0, last_v = 0, gap = 0, busy_cyc = 0;
  logic [7:0] sof_b0 = 8'h00;
  logic [BYTES-1:0] e_keep = '0;
  logic e_crc = 1'b0, e_len = 1'b0, e_al = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cyc++;
    if (valid) begin
      nw++;
      if (sof) begin nsof++; sof_b0 = data[7:0]; end
      if (eof) begin
        neof++; eof_nw = nw; e_keep = keep; e_crc = crc_ok; e_len = err_len; e_al = err_align;
      end else gap = cyc - last_v;
      last_v = cyc;
    end
  end

  logic [7:0] fr [0:1999];
  int flen = 0, per = 1, w0 = 0, e0 = 0, s0 = 0;

  task automatic build(input int npay, input int seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      fr[i] = 8'(i * 29 + seed);
      c = c ^ {24'h0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    fr[npay] = c[7:0]; fr[npay+1] = c[15:8]; fr[npay+2] = c[23:16]; fr[npay+3] = c[31:24];
    flen = npay + 4;
  endtask

  task automatic dib(input logic [1:0] d, input logic c);
    rxd = d; crs = c;
    repeat (per) @(negedge rmii_clk);
  endtask
  task automatic sbyte(input logic [7:0] b, input logic c);
    for (int k = 0; k < 4; k++) dib(b[2*k +: 2], c);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) dib(2'b00, 1'b0);
  endtask
  task automatic pre();
    for (int k = 0; k < 7; k++) sbyte(8'h55, 1'b1);
    sbyte(8'hD5, 1'b1);
  endtask
  task automatic snap();
    w0 = nw; e0 = neof; s0 = nsof;
  endtask
  task automatic send_frame(input int ncrs);
    snap();
    pre();
    for (int i = 0; i < flen; i++) sbyte(fr[i], (i < ncrs) ? 1'b1 : 1'b0);
    idle(48);
  endtask

  task automatic frame_chk(input string t, input int ew, input int ek, input bit ck,
                           input int ec, input int el, input int ea);
    chk({t, "_words"}, nw - w0, ew);
    chk({t, "_eofs"}, neof - e0, 1);
    chk({t, "_sofs"}, nsof - s0, 1);
    chk({t, "_eofpos"}, eof_nw - w0, ew);
    if (ck) chk({t, "_keep"}, 32'(e_keep), ek);
    chk({t, "_crc_ok"}, 32'(e_crc), ec);
    chk({t, "_err_len"}, 32'(e_len), el);
    chk({t, "_err_align"}, 32'(e_al), ea);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, wr;
    logic [7:0] tb_b;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_eof", 32'(eof), 0);
    chk("rst_keep", 32'(keep), 0);
    chk("rst_data", data, 0);
    @(negedge rmii_clk);
    idle(8);

    // 100M, 64-byte good frame
    build(60, 1); b0 = busy_cyc;
    send_frame(flen);
    frame_chk("t1", 16, 32'hF, 1, 1, 0, 0);
    chk("t1_first_da", 32'(sof_b0), 32'h01);
    chk("t1_busy_seen", 32'((busy_cyc - b0) > 0), 1);
    chk("t1_busy_end", 32'(busy), 0);

    // 100M, 65-byte good frame
    build(61, 2);
    send_frame(flen);
    frame_chk("t2", 17, 32'h1, 1, 1, 0, 0);

    // 100M, corrupted payload bit
    build(60, 3); fr[10] = fr[10] ^ 8'h04;
    send_frame(flen);
    frame_chk("t3", 16, 32'hF, 1, 0, 0, 0);

    // SFD immediately followed by crs_dv low: no output
    snap(); pre(); idle(48);
    chk("t0_words", nw - w0, 0);
    chk("t0_busy", 32'(busy), 0);

    // 10M, crs_dv drops one byte early; tail byte completes the frame
    fast_eth = 1'b0; per = 10; idle(4);
    build(60, 4);
    send_frame(flen - 1);
    frame_chk("t4", 16, 32'hF, 1, 1, 0, 0);
    chk("t4_word_spacing", gap, 320);

    // 100M, crs_dv drops mid byte 40
    fast_eth = 1'b1; per = 1; idle(4);
    build(60, 5); snap(); pre();
    for (int i = 0; i < 39; i++) sbyte(fr[i], 1'b1);
    tb_b = fr[39];
    dib(tb_b[1:0], 1'b1); dib(tb_b[3:2], 1'b1);
    idle(48);
    frame_chk("t5", 10, 32'h7, 1, 0, 1, 1);

    // 100M, 1600-byte frame overruns MAX_LEN
    build(1596, 6);
    send_frame(flen);
    frame_chk("t6", 381, 0, 0, 0, 1, 0);

    // reset mid-frame, then a good frame
    build(60, 7); snap(); pre();
    for (int i = 0; i < 20; i++) sbyte(fr[i], 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t7_busy_after_rst", 32'(busy), 0);
    chk("t7_valid_after_rst", 32'(valid), 0);
    wr = nw;
    @(negedge rmii_clk);
    for (int i = 20; i < flen; i++) sbyte(fr[i], 1'b1);
    idle(48);
    chk("t7_no_words", nw - wr, 0);
    chk("t7_no_eof", neof - e0, 0);
    chk("t7_busy_idle", 32'(busy), 0);
    build(60, 8);
    send_frame(flen);
    frame_chk("t8", 16, 32'hF, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
